// File: rtl/conv_output_streamer.sv
// conv_output_streamer: snapshots the conv result bus on start and streams it one element per beat.
// Define CONV_STREAM_RELU_EN to clamp negative elements to zero on the way out.
module conv_output_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int OH = 6,
    parameter int OW = 6,
    parameter int K = 6,
    localparam int CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [0:K*OH*OW*DATA_WIDTH-1]  conv_in,
    input  logic                           start,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CW-1:0]                  out_chan,
    output logic                           out_eoc,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);
    localparam int NP = OH * OW;
    localparam int NE = K * NP;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_pix;
    logic [CW-1:0]         r_chan;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mem [NE];

    logic                  w_load;
    logic                  w_pix_end;
    logic                  w_chan_end;
    logic [IW-1:0]         w_idx;
    logic [DATA_WIDTH-1:0] w_raw;
    logic [DATA_WIDTH-1:0] w_elem;

    assign w_load     = (r_state == IDLE) && start;
    assign w_pix_end  = r_pix == PW'(NP - 1);
    assign w_chan_end = r_chan == CW'(K - 1);
    assign w_idx      = IW'(int'(r_chan) * NP + int'(r_pix));
    assign w_raw      = r_mem[w_idx];

`ifdef CONV_STREAM_RELU_EN
    assign w_elem = w_raw[DATA_WIDTH-1] ? '0 : w_raw;
`else
    assign w_elem = w_raw;
`endif

    // Snapshot is deliberately left out of reset; it is always reloaded before use.
    for (genvar i = 0; i < NE; i++) begin : g_snap
        always_ff @(posedge clk) begin
            if (w_load) r_mem[i] <= conv_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pix   <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= STREAM;
                        r_pix   <= '0;
                        r_chan  <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (!w_pix_end) begin
                            r_pix <= r_pix + PW'(1);
                        end else begin
                            r_pix <= '0;
                            if (w_chan_end) begin
                                r_chan  <= '0;
                                r_state <= DONE;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_chan <= r_chan + CW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_valid ? w_elem : '0;
    assign out_chan  = r_chan;
    assign out_eoc   = r_valid && w_pix_end;
    assign out_last  = out_eoc && w_chan_end;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_conv_output_streamer.sv
// tb_conv_output_streamer: random-stimulus bench with a frame-level reference model.
module tb_conv_output_streamer;
    localparam int DW = 8;
    localparam int OH = 6;
    localparam int OW = 6;
    localparam int K  = 6;
    localparam int NP = OH * OW;
    localparam int NE = K * NP;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [0:NE*DW-1]  conv_in = '0;
    logic              start = 1'b0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [2:0]        out_chan;
    logic              out_eoc;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [0:DW-1]     s_conv = '0;
    logic              s_start = 1'b0;
    logic              s_ready = 1'b1;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic [0:0]        s_chan;
    logic              s_eoc;
    logic              s_last;
    logic              s_busy;
    logic              s_done;

    conv_output_streamer #(.DATA_WIDTH(DW), .OH(OH), .OW(OW), .K(K)) dut (
        .clk(clk), .reset(reset), .conv_in(conv_in), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_eoc(out_eoc),
        .out_last(out_last), .busy(busy), .done(done)
    );

    conv_output_streamer #(.DATA_WIDTH(DW), .OH(1), .OW(1), .K(1)) dut_s (
        .clk(clk), .reset(reset), .conv_in(s_conv), .start(s_start), .out_ready(s_ready),
        .out_valid(s_valid), .out_data(s_data), .out_chan(s_chan), .out_eoc(s_eoc),
        .out_last(s_last), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    int            beat = 0;
    int            done_cnt = 0;
    bit            rdy_rand = 1'b0;
    bit            stall = 1'b0;
    logic [DW-1:0] snap [NE];
    logic [DW-1:0] exp_m [NE];
    logic [DW-1:0] p_data;
    logic [2:0]    p_chan;
    logic          p_eoc;
    logic          p_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] v);
`ifdef CONV_STREAM_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Frame-level scoreboard: beat index alone determines element, channel and markers.
    always @(negedge clk) begin
        if (out_valid) begin
            if (beat >= NE) begin
                chk("overrun", beat, NE - 1);
            end else begin
                chk("data", out_data, exp_m[beat]);
                chk("chan", out_chan, beat / NP);
                chk("eoc", out_eoc, (beat % NP) == NP - 1);
                chk("last", out_last, beat == NE - 1);
                chk("busy_stream", busy, 1);
            end
            if (stall) begin
                chk("hold_data", out_data, p_data);
                chk("hold_chan", out_chan, p_chan);
                chk("hold_eoc", out_eoc, p_eoc);
                chk("hold_last", out_last, p_last);
            end
            stall  = !out_ready;
            p_data = out_data;
            p_chan = out_chan;
            p_eoc  = out_eoc;
            p_last = out_last;
            if (out_ready) beat++;
        end else begin
            stall = 1'b0;
        end
        if (done) begin
            done_cnt++;
            chk("done_at", beat, NE);
            chk("busy_done", busy, 1);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    task automatic start_frame(input int mode);
        for (int e = 0; e < NE; e++) begin
            snap[e] = (mode == 0) ? 8'(e) :
                      (mode == 2 && e == 0) ? 8'hF3 :
                      (mode == 2 && e == 1) ? 8'h05 : 8'($urandom);
            conv_in[e*DW +: DW] = snap[e];
            exp_m[e] = model(snap[e]);
        end
        beat = 0;
        done_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("latency", out_valid, 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("frame_len", beat, NE);
        chk("done_cnt", done_cnt, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_chan"}, out_chan, 0);
        chk({tag, "_eoc"}, out_eoc, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("rst");
        @(posedge clk);
        #1 reset = 1'b1;

        rdy_rand = 1'b0;
        start_frame(0);
        wait_done();

        rdy_rand = 1'b1;
        start_frame(0);
        wait_done();

        start_frame(1);
        for (int e = 0; e < NE; e++) conv_in[e*DW +: DW] = 8'hAA;
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("ignored_start", out_valid, 0);
        chk("single_done", done_cnt, 1);

        start_frame(1);
        for (int i = 0; i < 2000 && beat < 100; i++) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("abort");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", busy, 0);
        start_frame(1);
        wait_done();

        rdy_rand = 1'b0;
        start_frame(2);
        wait_done();

        @(posedge clk);
        #1 s_conv = 8'h3C;
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        @(negedge clk);
        chk("s_valid", s_valid, 1);
        chk("s_data", s_data, 8'h3C);
        chk("s_chan", s_chan, 0);
        chk("s_eoc", s_eoc, 1);
        chk("s_last", s_last, 1);
        @(negedge clk);
        chk("s_done", s_done, 1);
        chk("s_done_valid", s_valid, 0);
        @(negedge clk);
        chk("s_idle_busy", s_busy, 0);
        chk("s_idle_done", s_done, 0);
        @(posedge clk);
        #1 s_conv = 8'h42;
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        @(negedge clk);
        chk("s_restart_valid", s_valid, 1);
        chk("s_restart_data", s_data, 8'h42);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_output_streamer.md
# conv_output_streamer

Drains the flat multi-filter feature-map bus produced by the convolution layer and serialises it as a one-element-per-beat valid/ready stream for downstream pooling, storage or host readout. On a `start` pulse it snapshots the whole bus, then emits every element in channel-major, raster order. It marks channel and frame boundaries and pulses `done` when the last beat is accepted.

## Interface
Parameters:
- `DATA_WIDTH`, 8, bits per feature-map element.
- `OH`, 6, output map height (H-F+1).
- `OW`, 6, output map width (W-F+1).
- `K`, 6, number of channels (filters) on the bus.

Ports:
- `clk`  input  1  clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `conv_in`  input  [0:K*OH*OW*DATA_WIDTH-1]  flat convolution result; element e occupies `[e*DATA_WIDTH +: DATA_WIDTH]`, e = c*OH*OW + r*OW + col.
- `start`  input  1  one-cycle pulse; `conv_in` is valid in this cycle.
- `out_ready`  input  1  downstream can accept a beat.
- `out_valid`  output  1  `out_data` holds a valid element.
- `out_data`  output  [DATA_WIDTH-1:0]  current element.
- `out_chan`  output  [$clog2(K)-1:0]  channel index of current element (width min 1).
- `out_eoc`  output  1  current element is last of its channel.
- `out_last`  output  1  current element is last of the frame.
- `busy`  output  1  frame capture held or streaming.
- `done`  output  1  one-cycle pulse after final beat is accepted.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: `busy`=0, `out_valid`=0. On `start`=1: register `conv_in` into the internal snapshot, clear element counter `pix` (0..OH*OW-1) and channel counter `chan` (0..K-1), then go to STREAM.
- STREAM: `out_valid`=1. `out_data` = snapshot element `chan*OH*OW+pix`. Beat accepted when `out_valid && out_ready`.
  - On accept with `pix`<OH*OW-1: increment `pix`.
  - On accept with `pix`=OH*OW-1: clear `pix` and increment `chan`.
  - On accept with `chan`=K-1 and `pix`=OH*OW-1: go to DONE.
- DONE: `done`=1 for exactly one cycle, `out_valid`=0, then IDLE.
- `out_eoc` = (`pix`==OH*OW-1) while valid. `out_last` = `out_eoc && chan==K-1`. `out_chan` = `chan`.
- `start` in STREAM or DONE is ignored. The snapshot is not overwritten and the frame in progress is unaffected.
- `conv_in` may change freely after the `start` cycle; only the snapshot is streamed.
- Data is passed unmodified (bit-exact) unless the feature under Configuration is compiled in.
- Frame length is K*OH*OW beats. With defaults that is 216 beats, `out_eoc` on beats 35, 71, …, 215.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `out_valid`=0, `out_data`=0, `out_chan`=0, `out_eoc`=0, `out_last`=0, `busy`=0, `done`=0, counters 0. The snapshot is not reset.
- Reset mid-frame aborts immediately. No `done` is produced, and the next frame needs a new `start`.
- Latency: `start` sampled at edge N gives `out_valid`=1 with element 0 after edge N (cycle N+1).
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` to any output.
- Handshake: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_chan`, `out_eoc` and `out_last` stay stable.
- With `out_ready` held high, one beat per cycle. The last beat is accepted at cycle N+K*OH*OW, `done`=1 in cycle N+K*OH*OW+1, and IDLE follows.
- Earliest next accepted `start` is the cycle after `done`. `busy` is 1 from cycle N+1 through the `done` cycle inclusive.

## Configuration
- `CONV_STREAM_RELU_EN` defined: each element is treated as two's-complement. Negative values (MSB=1) are emitted as 0 and non-negative values pass through. The clamp is applied combinationally on the snapshot read, with no added latency.
- Not defined: elements pass unmodified. 8'hF3 is emitted as 8'hF3.

## Test plan
- Default params, `conv_in` element e = e[7:0], `start` pulse, `out_ready`=1 → 216 consecutive beats 0x00..0xD7 starting the cycle after `start`. `out_eoc` on beats 35/71/107/143/179/215, `out_last` only on beat 215, `done` one cycle after beat 215.
- Same stimulus, `out_ready` toggling 1,0,0,1 pseudo-randomly → same 216-value sequence. Outputs stable during every stall. `out_chan` steps 0→5 exactly at `out_eoc` acceptances.
- Change `conv_in` to all 8'hAA the cycle after `start`, and pulse `start` again mid-frame → stream still matches the snapshot from the first `start`. Second pulse ignored; exactly one `done`.
- Drive `reset`=0 at beat 100, release, then `start` → all outputs 0 during reset, no `done`. New frame restarts at element 0, `out_chan`=0.
- Element 0 = 8'hF3, element 1 = 8'h05 → with `CONV_STREAM_RELU_EN` the stream is 0x00, 0x05. Without it the stream is 0xF3, 0x05.
- Params K=1, OH=1, OW=1, `out_ready`=1 → single beat with `out_eoc`=`out_last`=1, then `done`, then IDLE, and the next `start` is accepted.
